// File: rtl/sdf_stage_ctrl.sv
// Phase controller for one single-delay-feedback FFT stage.
// It sequences the fill, butterfly, zero-pad and flush phases of a DEPTH-deep complex delay line.
module sdf_stage_ctrl #(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(2 * DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          shift_en,
    output logic          bf_sel,
    output logic          pad,
    output logic [AW-1:0] tw_addr,
    output logic          out_valid,
    output logic          busy,
    output logic          drop,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_BFLY  = 3'd2,
        ST_PAD   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(2 * DEPTH - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [CW-1:0] cnt_inc_s;
    logic          primed_r;
    logic          primed_nxt_s;
    logic          frame_done_r;
    logic          frame_done_nxt_s;
    logic          shift_s;
    logic          bf_sel_s;
    logic          pad_s;
    logic          drop_s;
    logic          out_valid_s;
    logic [AW-1:0] tw_addr_s;

    // 2*DEPTH is a power of two, so the natural CW-bit rollover is the modulo.
    assign cnt_inc_s = cnt_r + CW'(1);

    // Next-state, counter and per-cycle control decode.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        primed_nxt_s     = primed_r;
        frame_done_nxt_s = 1'b0;
        shift_s          = 1'b0;
        bf_sel_s         = 1'b0;
        pad_s            = 1'b0;
        drop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                primed_nxt_s = 1'b0;
                shift_s      = in_valid;
                if (in_valid) begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = CW'(1);
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            end
            ST_FILL: begin
                shift_s   = 1'b1;
                cnt_nxt_s = cnt_inc_s;
                if (in_valid) begin
                    state_nxt_s = (cnt_r == CNT_HALF_LAST) ? ST_BFLY : ST_FILL;
                end else if ((cnt_r == {CW{1'b0}}) && primed_r) begin
                    // Frame boundary: this idle cycle is already the first flush cycle.
                    pad_s       = 1'b1;
                    state_nxt_s = ST_FLUSH;
                end else begin
                    pad_s       = 1'b1;
                    state_nxt_s = ST_PAD;
                end
            end
            ST_BFLY: begin
                shift_s      = 1'b1;
                bf_sel_s     = 1'b1;
                primed_nxt_s = 1'b1;
                cnt_nxt_s    = cnt_inc_s;
                if (in_valid) begin
                    state_nxt_s = (cnt_r == CNT_LAST) ? ST_FILL : ST_BFLY;
                end else begin
                    pad_s       = 1'b1;
                    state_nxt_s = (cnt_r == CNT_LAST) ? ST_FLUSH : ST_PAD;
                end
            end
            ST_PAD: begin
                shift_s      = 1'b1;
                pad_s        = 1'b1;
                bf_sel_s     = cnt_r[CW-1];
                primed_nxt_s = primed_r | cnt_r[CW-1];
                drop_s       = in_valid;
                cnt_nxt_s    = cnt_inc_s;
                state_nxt_s  = (cnt_r == CNT_LAST) ? ST_FLUSH : ST_PAD;
            end
            ST_FLUSH: begin
                shift_s = 1'b1;
                pad_s   = 1'b1;
                drop_s  = in_valid;
                if (cnt_r == CNT_HALF_LAST) begin
                    state_nxt_s      = ST_IDLE;
                    cnt_nxt_s        = {CW{1'b0}};
                    primed_nxt_s     = 1'b0;
                    frame_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                cnt_nxt_s    = {CW{1'b0}};
                primed_nxt_s = 1'b0;
            end
        endcase
    end

    // Output-valid and twiddle address derived from the decoded controls.
    always_comb begin
        out_valid_s = shift_s & (bf_sel_s | primed_r);
        if (!bf_sel_s && out_valid_s) begin
            tw_addr_s = cnt_r[AW-1:0];
        end else begin
            tw_addr_s = {AW{1'b0}};
        end
    end

    // Controller state, phase counter, primed flag and frame-done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            primed_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            primed_r     <= primed_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Held reset blocks the in_valid-to-shift_en path so nothing moves while rst_n is low.
    assign shift_en   = shift_s & rst_n;
    assign bf_sel     = bf_sel_s & rst_n;
    assign pad        = pad_s & rst_n;
    assign tw_addr    = rst_n ? tw_addr_s : {AW{1'b0}};
    assign out_valid  = out_valid_s & rst_n;
    assign busy       = (state_r != ST_IDLE) & rst_n;
    assign drop       = drop_s & rst_n;
    assign frame_done = frame_done_r & rst_n;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl (DEPTH=16) against a frame-level reference model.
module tb_sdf_stage_ctrl;

    localparam int D  = 16;
    localparam int AW = $clog2(D);
    localparam int VW = AW + 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          shift_en;
    logic          bf_sel;
    logic          pad;
    logic [AW-1:0] tw_addr;
    logic          out_valid;
    logic          busy;
    logic          drop;
    logic          frame_done;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .shift_en   (shift_en),
        .bf_sel     (bf_sel),
        .pad        (pad),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .busy       (busy),
        .drop       (drop),
        .frame_done (frame_done)
    );

    int n_asserts = 0;
    int n_fails   = 0;
    int ov_cnt    = 0;
    int fd_cnt    = 0;

    // Reference model: samples accepted in the current frame plus a drain schedule.
    int m_n     = 0;
    bit m_drain = 1'b0;
    bit m_fd    = 1'b0;
    int m_dk    = 0;
    int m_dlen  = 0;
    int m_npad  = 0;
    int m_p     = 0;
    int m_nsav  = 0;

    function automatic logic [VW-1:0] pack(input bit s, input bit b, input bit p, input int tw,
                                           input bit ov, input bit bu, input bit dr, input bit fd);
        logic [AW-1:0] t;
        t = AW'(tw);
        return {s, b, p, t, ov, bu, dr, fd};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input string tag);
        logic [VW-1:0] exp;
        bit s, b, p, ov, bu, dr;
        int tw, q;
        @(negedge clk);
        in_valid = v;
        #1;
        s = 1'b0; b = 1'b0; p = 1'b0; ov = 1'b0; bu = 1'b0; dr = 1'b0; tw = 0;
        if (!m_drain && m_n > 0 && !v) begin
            // Frame ends: zero-pad to the end of the 2*D period (unless already there), then flush D.
            m_nsav  = m_n;
            m_p     = m_n % (2 * D);
            m_npad  = (m_p == 0) ? 0 : 2 * D - m_p;
            m_dlen  = m_npad + D;
            m_dk    = 0;
            m_drain = 1'b1;
        end
        if (m_drain) begin
            bu = 1'b1; s = 1'b1; p = 1'b1; dr = v;
            if (m_dk < m_npad) begin
                q  = m_p + m_dk;
                b  = (q >= D);
                ov = b || (m_nsav > D);
                tw = (!b && ov) ? q % D : 0;
            end else begin
                ov = 1'b1;
                tw = m_dk - m_npad;
            end
        end else if (v) begin
            bu = (m_n > 0);
            s  = 1'b1;
            q  = m_n % (2 * D);
            b  = (q >= D);
            ov = (m_n >= D);
            tw = (!b && ov) ? q % D : 0;
        end
        exp = pack(s, b, p, tw, ov, bu, dr, m_fd);
        check(tag, {shift_en, bf_sel, pad, tw_addr, out_valid, busy, drop, frame_done}, exp);
        ov_cnt += int'(out_valid);
        fd_cnt += int'(frame_done);
        m_fd = 1'b0;
        if (m_drain) begin
            m_dk++;
            if (m_dk == m_dlen) begin
                m_drain = 1'b0;
                m_n     = 0;
                m_fd    = 1'b1;
            end
        end else if (v) begin
            m_n++;
        end
    endtask

    // ns samples, then drain (mode 0: idle input, 2: random input to provoke drops), then the done cycle.
    task automatic run_frame(input int ns, input int mode, input bit fd_v, input string tag);
        for (int i = 0; i < ns; i++) step(1'b1, tag);
        step(1'b0, tag);
        while (m_drain) step((mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0, tag);
        step(fd_v, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check(tag, {shift_en, bf_sel, pad, tw_addr, out_valid, busy, drop, frame_done}, {VW{1'b0}});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check(tag, {shift_en, bf_sel, pad, tw_addr, out_valid, busy, drop, frame_done}, {VW{1'b0}});
        rst_n   = 1'b1;
        m_n     = 0;
        m_drain = 1'b0;
        m_fd    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("por", {shift_en, bf_sel, pad, tw_addr, out_valid, busy, drop, frame_done}, {VW{1'b0}});
        rst_n = 1'b1;
        step(1'b0, "idle");

        ov_cnt = 0; fd_cnt = 0;
        run_frame(64, 0, 1'b0, "full64");
        check_int("full64_ov", ov_cnt, 64);
        check_int("full64_fd", fd_cnt, 1);

        ov_cnt = 0; fd_cnt = 0;
        run_frame(20, 0, 1'b0, "part20");
        check_int("part20_ov", ov_cnt, 32);

        ov_cnt = 0; fd_cnt = 0;
        run_frame(5, 0, 1'b0, "short5");
        check_int("short5_ov", ov_cnt, 32);
        check_int("short5_fd", fd_cnt, 1);

        // Drops during pad/flush, then a new frame launched in the frame_done cycle.
        run_frame(40, 2, 1'b1, "drops40");
        run_frame(15, 2, 1'b1, "b2b");
        run_frame(31, 0, 1'b0, "b2b2");

        for (int i = 0; i < 22; i++) step(1'b1, "pre_rst");
        do_reset("rst_mid");
        run_frame(16, 0, 1'b0, "post_rst");
        run_frame(1, 0, 1'b0, "one");
        run_frame(32, 2, 1'b0, "exact32");

        for (int k = 0; k < 12; k++) begin
            run_frame(int'($urandom_range(80, 1)), 2, 1'($urandom_range(1, 0)), "rnd_frame");
        end
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(11, 0) != 0), "rnd_stream");
        end
        do_reset("rst_rnd");
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(7, 0) != 0), "rnd_tail");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
